pc_sequencer: RTL

- Parametrised program counter for the picoMIPS fetch stage.
- Adds the following to plain increment:
  - conditional PC-relative branch
  - absolute jump
  - call/return through a small hardware return-address stack
  - stall
- Drives the program-memory address every cycle.
- Takes an encoded operation from the decoder/controller.

---
 rtl/pc_pkg.sv | 44 ++++
 rtl/pc_sequencer_return_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the picoMIPS program-counter sequencer.
`ifndef PROGRAM_CODE_SIZE
`define PROGRAM_CODE_SIZE 8
`endif

package pc_pkg;

    // Operation codes driven by the decoder; 6 and 7 are reserved (behave as hold).
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_JUMP   = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } pc_op_t;

    // Working width of the sign-extension helper; callers truncate to PC width.
    localparam int EXT_W = 32;

    // Sign-extends the low src_w bits of value to EXT_W bits.
    function automatic logic [EXT_W-1:0] sign_extend(input logic [EXT_W-1:0] value,
                                                     input int src_w);
        logic [EXT_W-1:0] result;
        logic             sign_bit;
        sign_bit = 1'b0;
        for (int i = 0; i < EXT_W; i++) begin
            if (i == src_w - 1) begin
                sign_bit = value[i];
            end else begin
                sign_bit = sign_bit;
            end
        end
        for (int i = 0; i < EXT_W; i++) begin
            if (i < src_w) begin
                result[i] = value[i];
            end else begin
                result[i] = sign_bit;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO return-address stack; the caller guarantees push and pop are exclusive.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] top_idx_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer counts live entries; the top entry sits one slot below it.
    assign wr_idx_s  = IDX_W'(ptr_r);
    assign top_idx_s = IDX_W'(ptr_r - PTR_W'(1));
    assign empty     = (ptr_r == {PTR_W{1'b0}});
    assign full      = (ptr_r == PTR_W'(DEPTH));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign top_data  = mem_r[top_idx_s];

    // Stack pointer: cleared on reset, moves by one on a legal push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (do_push_s) begin
            ptr_r <= ptr_r + PTR_W'(1);
        end else if (do_pop_s) begin
            ptr_r <= ptr_r - PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS fetch-stage program counter: increment, branch, jump, call/return, stall.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                PC_W         = `PROGRAM_CODE_SIZE,
    parameter int                OFFSET_W     = 8,
    parameter int                STACK_DEPTH  = 4,
    parameter logic [PC_W-1:0]   RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [2:0]          pc_op,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [PC_W-1:0]     target,
    output logic [PC_W-1:0]     pc_out,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                stack_err
);

    pc_op_t          op_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] pc_plus1_s;
    logic [PC_W-1:0] offset_ext_s;
    logic [PC_W-1:0] top_data_s;
    logic            err_r;
    logic            err_set_s;
    logic            push_s;
    logic            pop_s;
    logic            empty_s;
    logic            full_s;

    assign op_s         = pc_op_t'(pc_op);
    assign pc_plus1_s   = pc_r + PC_W'(1);
    assign offset_ext_s = PC_W'(sign_extend(EXT_W'(offset), OFFSET_W));

    return_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_plus1_s),
        .top_data  (top_data_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Next-PC selection; stall suppresses every state change including stack traffic.
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        if (stall) begin
            pc_next_s = pc_r;
        end else begin
            case (op_s)
                OP_HOLD:   pc_next_s = pc_r;
                OP_INC:    pc_next_s = pc_plus1_s;
                OP_BRANCH: begin
                    if (branch_taken) begin
                        pc_next_s = pc_r + offset_ext_s;
                    end else begin
                        pc_next_s = pc_plus1_s;
                    end
                end
                OP_JUMP:   pc_next_s = target;
                OP_CALL: begin
                    if (full_s) begin
                        // Overflowing call degrades to a plain increment.
                        pc_next_s = pc_plus1_s;
                        err_set_s = 1'b1;
                    end else begin
                        pc_next_s = target;
                        push_s    = 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty_s) begin
                        pc_next_s = pc_r;
                        err_set_s = 1'b1;
                    end else begin
                        pc_next_s = top_data_s;
                        pop_s     = 1'b1;
                    end
                end
                default:   pc_next_s = pc_r;
            endcase
        end
    end

    // PC and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= RESET_VECTOR;
            err_r <= 1'b0;
        end else begin
            pc_r  <= pc_next_s;
            err_r <= err_r | err_set_s;
        end
    end

    assign pc_out      = pc_r;
    assign stack_err   = err_r;
    assign stack_empty = empty_s;
    assign stack_full  = full_s;

endmodule
